// File: rtl/sha_pkg.sv
// Shared constants and types for the SHA chaining-value accumulator:
// the two standard initial hash values and the FSM state encoding.
package sha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [31:0] IV_SHA256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV_SHA224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] iv_word(input logic mode, input logic [2:0] idx);
    return mode ? IV_SHA224[idx] : IV_SHA256[idx];
  endfunction

endpackage

// File: rtl/sha_iv_sel.sv
// Combinational IV lookup: mode 0 selects SHA-256, mode 1 selects SHA-224.
module sha_iv_sel
  import sha_pkg::*;
(
  input  logic        mode,
  input  logic [2:0]  idx,
  output logic [31:0] iv
);

  assign iv = iv_word(mode, idx);

endmodule

// File: rtl/sha_chain_accum.sv
// Accumulates compression results into the SHA chaining value, counts blocks
// and publishes the final chaining value as the digest.
//
// state     | meaning
// ST_IDLE   | waiting for start; chain/count hold their last values
// ST_ACTIVE | accepting compression results on h_in
// ST_DONE   | one-cycle digest_valid pulse, then back to idle
module sha_chain_accum
  import sha_pkg::*;
#(
  parameter int NUM_WORDS = 8,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [NUM_WORDS*32-1:0] h_in,
  output logic [NUM_WORDS*32-1:0] chain_out,
  output logic                    busy,
  output logic [CNT_W-1:0]        blk_cnt,
  output logic                    cnt_ovf,
  output logic                    digest_valid,
  output logic [NUM_WORDS*32-1:0] digest
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;

  logic                    load_iv;
  logic                    accept;
  logic [NUM_WORDS*32-1:0] sum_flat;

  // start in DONE is ignored; start in ACTIVE aborts and wins over in_valid
  assign load_iv = start && (state != ST_DONE);
  assign accept  = (state == ST_ACTIVE) && in_valid && !start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!start && accept && in_last) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    busy         = 1'b0;
    digest_valid = 1'b0;
    case (state)
      ST_ACTIVE: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: begin
        busy         = 1'b1;
        digest_valid = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
    logic [31:0] iv_sel;
    logic [31:0] chain;
    logic [31:0] sum;

    sha_iv_sel u_iv_sel (
      .mode (mode),
      .idx  (3'(i)),
      .iv   (iv_sel)
    );

    assign sum = chain + h_in[32*i +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       chain <= IV_SHA256[i];
      else if (load_iv) chain <= iv_sel;
      else if (accept)  chain <= sum;
    end

    assign sum_flat[32*i +: 32]  = sum;
    assign chain_out[32*i +: 32] = chain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
      cnt_ovf <= 1'b0;
    end else if (load_iv) begin
      blk_cnt <= '0;
      cnt_ovf <= 1'b0;
    end else if (accept) begin
      if (blk_cnt == CNT_MAX) cnt_ovf <= 1'b1;
      else                    blk_cnt <= blk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  digest <= '0;
    else if (accept && in_last)  digest <= sum_flat;
  end

endmodule

// File: tb/tb_sha_chain_accum.sv
// Directed bench for sha_chain_accum: a software chaining model feeds a digest
// scoreboard; a second instance with a 2-bit counter covers saturation.
module tb_sha_chain_accum;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, mode, in_valid, in_last;
  logic [255:0] h_in;

  logic         in_ready, busy, cnt_ovf, digest_valid;
  logic [255:0] chain_out, digest;
  logic [15:0]  blk_cnt;

  logic         s_in_ready, s_busy, s_cnt_ovf, s_digest_valid;
  logic [255:0] s_chain_out, s_digest;
  logic [1:0]   s_blk_cnt;

  always #5 clk = ~clk;

  sha_chain_accum dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .h_in(h_in),
    .chain_out(chain_out), .busy(busy), .blk_cnt(blk_cnt), .cnt_ovf(cnt_ovf),
    .digest_valid(digest_valid), .digest(digest)
  );

  sha_chain_accum #(.NUM_WORDS(8), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_last(in_last), .h_in(h_in),
    .chain_out(s_chain_out), .busy(s_busy), .blk_cnt(s_blk_cnt), .cnt_ovf(s_cnt_ovf),
    .digest_valid(s_digest_valid), .digest(s_digest)
  );

  logic [31:0] iv256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] iv224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                             32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  logic [31:0]  chain_m [8];
  int           cnt_m, cnt_s;
  bit           ovf_s;
  bit           dv_exp;
  logic [255:0] digest_q [$];
  logic [255:0] last_digest;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack_model();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = chain_m[i];
    return v;
  endfunction

  function automatic logic [255:0] pack_iv(input bit m);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = m ? iv224[i] : iv256[i];
    return v;
  endfunction

  // advance one edge, then check the digest pulse against the scoreboard
  task automatic tick();
    logic [255:0] e;
    @(posedge clk);
    #1;
    chk("digest_valid", {255'd0, digest_valid}, {255'd0, dv_exp});
    if (digest_valid && digest_q.size() > 0) begin
      e = digest_q.pop_front();
      chk("digest", digest, e);
      last_digest = e;
    end
    dv_exp = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) chain_m[i] = iv256[i];
    cnt_m = 0; cnt_s = 0; ovf_s = 1'b0;
    digest_q.delete();
    dv_exp = 1'b0;
  endtask

  task automatic do_start(input bit m);
    start = 1'b1; mode = m;
    tick();
    start = 1'b0; mode = 1'b0;
    for (int i = 0; i < 8; i++) chain_m[i] = m ? iv224[i] : iv256[i];
    cnt_m = 0; cnt_s = 0; ovf_s = 1'b0;
    chk("start_chain", chain_out, pack_model());
    chk("start_cnt", {240'd0, blk_cnt}, 256'd0);
    chk("start_ready", {255'd0, in_ready}, 256'd1);
  endtask

  task automatic do_block(input logic [255:0] h, input bit last);
    in_valid = 1'b1; in_last = last; h_in = h;
    for (int i = 0; i < 8; i++) chain_m[i] = chain_m[i] + h[32*i +: 32];
    if (cnt_m < 65535) cnt_m++;
    if (cnt_s == 3) ovf_s = 1'b1; else cnt_s++;
    if (last) begin
      digest_q.push_back(pack_model());
      dv_exp = 1'b1;
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0; h_in = '0;
    chk("chain", chain_out, pack_model());
    chk("blk_cnt", {240'd0, blk_cnt}, 256'(cnt_m));
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", {255'd0, in_ready}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_chain", chain_out, pack_iv(1'b0));
    chk("rst_cnt", {239'd0, cnt_ovf, blk_cnt}, 256'd0);
    chk("rst_digest", digest, 256'd0);
    chk("rst_dv", {255'd0, digest_valid}, 256'd0);
  endtask

  initial begin
    logic [255:0] h;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; h_in = '0;
    model_reset();
    last_digest = '0;
    #12;
    chk_reset_vals();
    rst_n = 1'b1;
    tick();

    // SHA-256 IV plus one in every word
    do_start(1'b0);
    h = '0;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = 32'h1;
    do_block(h, 1'b1);
    chk("v1_word0", {224'd0, digest[31:0]}, {224'd0, 32'h6a09e668});
    chk("v1_word7", {224'd0, digest[255:224]}, {224'd0, 32'h5be0cd1a});
    chk("v1_busy_done", {255'd0, busy}, 256'd1);
    tick();
    chk("idle_busy", {255'd0, busy}, 256'd0);
    chk("idle_hold_chain", chain_out, pack_model());
    chk("idle_hold_cnt", {240'd0, blk_cnt}, 256'd1);
    // in_valid while idle is ignored
    in_valid = 1'b1; h_in = {8{32'h12345678}};
    tick();
    in_valid = 1'b0; h_in = '0;
    chk("idle_ignore_chain", chain_out, pack_model());
    chk("idle_digest_hold", digest, last_digest);

    // SHA-224 IV with zero block
    do_start(1'b1);
    do_block('0, 1'b1);
    chk("v2_word0", {224'd0, digest[31:0]}, {224'd0, 32'hc1059ed8});
    chk("v2_word7", {224'd0, digest[255:224]}, {224'd0, 32'hbefa4fa4});
    // start during DONE is ignored: back to idle
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    chk("done_start_ignored", {254'd0, busy, in_ready}, 256'd0);

    // word 0 wraps without carrying into word 1, then random blocks
    do_start(1'b0);
    h = '0; h[31:0] = 32'h95f61999;
    do_block(h, 1'b0);
    chk("wrap_w0", {224'd0, chain_out[31:0]}, 256'd0);
    chk("wrap_w1", {224'd0, chain_out[63:32]}, {224'd0, 32'hbb67ae85});
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
      do_block(h, b == 2);
    end
    tick();

    // counter saturation in the 2-bit instance
    do_start(1'b0);
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
      do_block(h, 1'b0);
    end
    chk("sat_cnt", {254'd0, s_blk_cnt}, 256'(cnt_s));
    chk("sat_ovf", {255'd0, s_cnt_ovf}, {255'd0, ovf_s});
    chk("sat_cnt_lit", {254'd0, s_blk_cnt}, 256'd3);
    chk("big_no_ovf", {255'd0, cnt_ovf}, 256'd0);
    do_start(1'b0);
    chk("sat_clear", {253'd0, s_cnt_ovf, s_blk_cnt}, 256'd0);

    // abort: start with a concurrent in_valid drops the block
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
      do_block(h, 1'b0);
    end
    in_valid = 1'b1; h_in = {8{32'hdeadbeef}}; in_last = 1'b1;
    do_start(1'b0);
    in_valid = 1'b0; in_last = 1'b0; h_in = '0;
    chk("abort_busy", {255'd0, busy}, 256'd1);
    h = '0; h[63:32] = 32'h00000010;
    do_block(h, 1'b1);
    tick();

    // asynchronous reset mid-message
    do_start(1'b1);
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    do_block(h, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_vals();
    #1 rst_n = 1'b1;
    in_valid = 1'b1; in_last = 1'b1; h_in = {8{32'h1}};
    tick();
    tick();
    in_valid = 1'b0; in_last = 1'b0; h_in = '0;
    chk("post_rst_ready", {255'd0, in_ready}, 256'd0);
    chk("post_rst_chain", chain_out, pack_iv(1'b0));
    chk("sb_empty", 256'(digest_q.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha_chain_accum.md
SHA_CHAIN_ACCUM -- requirements
Module: sha_chain_accum

Interface
REQ-001 Parameter NUM_WORDS, default 8, number of 32-bit chaining words; legal range 1..8.
REQ-002 Parameter CNT_W, default 16, width of the block counter.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  begin new message; loads IV selected by mode.
REQ-007 mode  in  1  IV select, sampled only with start: 0=SHA-256, 1=SHA-224.
REQ-008 in_valid  in  1  compression result on h_in is valid.
REQ-009 in_ready  out  1  block accepts h_in this cycle.
REQ-010 in_last  in  1  qualifies in_valid; marks final block of message.
REQ-011 h_in  in  NUM_WORDS*32  compression working variables; word i at bits [32i+31:32i]; word 0 = a.
REQ-012 chain_out  out  NUM_WORDS*32  current chaining value H0..H(N-1), same packing.
REQ-013 busy  out  1  high in ACTIVE and DONE.
REQ-014 blk_cnt  out  CNT_W  blocks accumulated since last start.
REQ-015 cnt_ovf  out  1  sticky; block count exceeded 2^CNT_W-1.
REQ-016 digest_valid  out  1  one-cycle pulse; digest holds final value.
REQ-017 digest  out  NUM_WORDS*32  final chaining value; held until next digest_valid.

Function
REQ-018 FSM states IDLE, ACTIVE, DONE; in_ready=1 only in ACTIVE.
REQ-019 IDLE: start -> chain := IV(mode), blk_cnt := 0, cnt_ovf := 0, next ACTIVE.
REQ-020 ACTIVE, in_valid & in_ready & !start: chain[i] := chain[i] + h_in[i] mod 2^32, every word in parallel, same edge.
REQ-021 Same accept: blk_cnt := blk_cnt+1, saturating at 2^CNT_W-1; an accept at saturation sets cnt_ovf.
REQ-022 Accept with in_last=1 -> next DONE; digest := updated chain on the same edge.
REQ-023 DONE lasts exactly one cycle, digest_valid=1 during it, then IDLE; latency last accept -> digest_valid = 1 cycle.
REQ-024 start in ACTIVE aborts: reload IV, clear blk_cnt/cnt_ovf, stay ACTIVE; a concurrent in_valid is dropped, not accumulated.
REQ-025 start in DONE is ignored; in_valid outside ACTIVE is ignored.
REQ-026 chain_out, blk_cnt, cnt_ovf hold in IDLE after DONE until next start.
REQ-027 NUM_WORDS<8: IV uses words 0..NUM_WORDS-1 of the selected set.
REQ-028 mode is don't-care except on a start cycle; latched mode is not exported.

Reset
REQ-029 rst_n low: state IDLE, chain := SHA-256 IV, blk_cnt 0, cnt_ovf 0, digest 0, digest_valid 0, in_ready 0, busy 0.
REQ-030 Reset mid-message discards all progress; no digest_valid is produced for the aborted message.

Structure
REQ-031 Package sha_pkg holds SHA-256 and SHA-224 IV constant arrays (8 x 32) and the FSM state enum.
REQ-032 One sub-module sha_iv_sel: combinational, mode + word index -> 32-bit IV word from sha_pkg.
REQ-033 Word adders are generated per word in sha_chain_accum, not as separate modules.

Verification
REQ-034 Reset, start mode=0, one block h_in all words 0x00000001, in_last=1 -> next cycle digest_valid=1, digest word0=0x6a09e668, word7=0x5be0cd1a, blk_cnt=1.
REQ-035 start mode=1, one block h_in all zero, last -> digest word0=0xc1059ed8, word7=0xbefa4fa4.
REQ-036 mode=0, h_in word0=0x95f61999 -> chain word0 wraps to 0x00000000, other words unaffected by carry.
REQ-037 CNT_W=2, five non-last blocks -> blk_cnt=3, cnt_ovf=1; next start clears both.
REQ-038 ACTIVE after 2 blocks, start with in_valid=1 same cycle -> chain_out = IV, blk_cnt=0, block not added, no digest_valid.
REQ-039 rst_n pulsed low asynchronously mid-message -> outputs immediately at REQ-029 values; in_ready=0 until next start.
